// File: rtl/turfbus_pkg.sv
// turfbus shared types and constants.
// Used by the SURF transmitter and the TURF-side receiver model.
package turfbus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    PRE,
    DATA,
    CKS,
    GAP
  } state_e;

  localparam logic [7:0] PREAMBLE_DEF = 8'hA5;
  localparam int         WCNT_W       = 12;

endpackage

// File: rtl/turfbus_sync2.sv
// Two-flop synchronizer for asynchronous single-bit inputs.
// Shared by the TREQ grant and PPS paths.
module turfbus_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic s1;
  (* ASYNC_REG = "TRUE" *) logic s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

endmodule

// File: rtl/turfbus_tx.sv
// SURF-to-TURF transmitter: frames 32-bit event words onto the TD bus.
// Frame = preamble, data bytes LSB first, XOR checksum, then an idle gap.
module turfbus_tx
  import turfbus_pkg::*;
#(
  parameter logic [7:0] PREAMBLE   = PREAMBLE_DEF,
  parameter int         MAX_WORDS  = 2048,
  parameter int         GAP_CYCLES = 4,
  parameter int         TIMEOUT    = 1024
) (
  input  logic        clk_i,
  input  logic        rst_neg_i,
  input  logic [31:0] dat_i,
  input  logic        valid_i,
  input  logic        last_i,
  output logic        ready_o,
  input  logic        TREQ_neg,
  output logic        SREQ_neg,
  output logic [7:0]  td_o,
  output logic        sclk_en_o,
  output logic        busy_o,
  output logic        overflow_o,
  output logic        timeout_o,
  output logic [15:0] frame_count_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [TW-1:0]     T_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0]     G_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [WCNT_W-1:0] W_MAX  = WCNT_W'(MAX_WORDS);

  state_e state;
  state_e state_nx;

  logic              treq_a;
  logic              grant_s;
  logic [TW-1:0]     wait_cnt;
  logic [GW-1:0]     gap_cnt;
  logic [WCNT_W-1:0] wcnt;
  logic [31:0]       word_q;
  logic [1:0]        bidx;
  logic              full;
  logic              cur_last;
  logic [7:0]        cks;
  logic [7:0]        td_q;
  logic [7:0]        byte_o;
  logic [7:0]        word_byte;
  logic              emit;
  logic              load;
  logic              rdy;
  logic              byte3;
  logic              at_max;
  logic              close;
  logic [15:0]       fcnt;

  assign treq_a = ~TREQ_neg;

  turfbus_sync2 u_sync (
    .clk   (clk_i),
    .rst_n (rst_neg_i),
    .d     (treq_a),
    .q     (grant_s)
  );

  assign word_byte = word_q[{bidx, 3'b000} +: 8];
  assign byte3     = full && (bidx == 2'd3);
  assign at_max    = (wcnt == W_MAX);
  assign close     = cur_last || at_max;

  always_comb begin
    state_nx = state;
    rdy      = 1'b0;
    emit     = 1'b0;
    load     = 1'b0;
    byte_o   = 8'h00;
    unique case (state)
      IDLE: begin
        if (valid_i) state_nx = REQ;
      end
      REQ: begin
        if (grant_s) state_nx = PRE;
      end
      PRE: begin
        emit     = 1'b1;
        byte_o   = PREAMBLE;
        state_nx = DATA;
      end
      DATA: begin
        byte_o = td_q;
        if (!full) begin
          rdy = 1'b1;
          if (valid_i) begin
            emit   = 1'b1;
            load   = 1'b1;
            byte_o = dat_i[7:0];
          end
        end else begin
          emit   = 1'b1;
          byte_o = word_byte;
          // Preload the next word on byte 3 unless the frame closes here
          if (byte3) begin
            if (close) begin
              state_nx = CKS;
            end else begin
              rdy  = 1'b1;
              load = valid_i;
            end
          end
        end
      end
      CKS: begin
        emit     = 1'b1;
        byte_o   = cks;
        state_nx = GAP;
      end
      GAP: begin
        if (gap_cnt == G_LAST) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_neg_i) begin
    if (!rst_neg_i) begin
      state    <= IDLE;
      wait_cnt <= '0;
      gap_cnt  <= '0;
      wcnt     <= '0;
      word_q   <= '0;
      bidx     <= '0;
      full     <= 1'b0;
      cur_last <= 1'b0;
      cks      <= '0;
      td_q     <= '0;
      fcnt     <= '0;
    end else begin
      state <= state_nx;
      td_q  <= byte_o;

      if (state == REQ && wait_cnt != T_LAST) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end

      if (state == GAP) begin
        gap_cnt <= gap_cnt + 1'b1;
      end else begin
        gap_cnt <= '0;
      end

      if (state == PRE) begin
        cks <= PREAMBLE;
      end else if (state == DATA && emit) begin
        cks <= cks ^ byte_o;
      end

      if (state == PRE) begin
        wcnt <= '0;
        full <= 1'b0;
        bidx <= '0;
      end else if (load) begin
        word_q   <= dat_i;
        cur_last <= last_i;
        wcnt     <= wcnt + 1'b1;
        full     <= 1'b1;
        bidx     <= full ? 2'd0 : 2'd1;
      end else if (state == DATA && full) begin
        bidx <= bidx + 1'b1;
        if (bidx == 2'd3) full <= 1'b0;
      end

      if (state == CKS) fcnt <= fcnt + 1'b1;
    end
  end

  assign ready_o       = rdy;
  assign td_o          = byte_o;
  assign sclk_en_o     = emit;
  assign busy_o        = (state != IDLE);
  assign SREQ_neg      = !(state inside {REQ, PRE, DATA, CKS});
  assign overflow_o    = (state == DATA) && byte3 && !cur_last && at_max;
  assign timeout_o     = (state == REQ) && !grant_s && (wait_cnt == T_LAST);
  assign frame_count_o = fcnt;

endmodule

// File: tb/tb_turfbus_tx.sv
// Directed bench for turfbus_tx (MAX_WORDS overridden to 4).
// Frames are captured from td_o/sclk_en_o and checked against expected bytes.
module tb_turfbus_tx;

  logic        clk = 1'b0;
  logic        rst_neg_i;
  logic [31:0] dat_i;
  logic        valid_i;
  logic        last_i;
  logic        ready_o;
  logic        TREQ_neg;
  logic        SREQ_neg;
  logic [7:0]  td_o;
  logic        sclk_en_o;
  logic        busy_o;
  logic        overflow_o;
  logic        timeout_o;
  logic [15:0] frame_count_o;

  turfbus_tx #(
    .MAX_WORDS (4)
  ) dut (
    .clk_i         (clk),
    .rst_neg_i     (rst_neg_i),
    .dat_i         (dat_i),
    .valid_i       (valid_i),
    .last_i        (last_i),
    .ready_o       (ready_o),
    .TREQ_neg      (TREQ_neg),
    .SREQ_neg      (SREQ_neg),
    .td_o          (td_o),
    .sclk_en_o     (sclk_en_o),
    .busy_o        (busy_o),
    .overflow_o    (overflow_o),
    .timeout_o     (timeout_o),
    .frame_count_o (frame_count_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  rx[$];
  int          rxc[$];
  int          to_q[$];
  logic [7:0]  exp_q[$];
  logic [31:0] wq[8];
  bit          lq[8];

  int cyc = 0;
  int req_start = 0;
  int t_gnt = 0;
  int gnt_dly = 5;
  int gcnt = 0;
  int n_ov = 0;
  int gap_cnt = 0;
  bit sreq_prev = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic expire(input string tag);
    n_vec++;
    n_err++;
    $error("FAIL %s: wait bound expired", tag);
  endtask

  // Capture bytes, pulses and request timing; act as the TURF granter.
  initial begin
    TREQ_neg = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_neg_i) begin
        if (sclk_en_o) begin
          rx.push_back(td_o);
          rxc.push_back(cyc);
        end
        if (!SREQ_neg && sreq_prev) req_start = cyc;
        if (timeout_o) to_q.push_back(cyc - req_start + 1);
        if (overflow_o) n_ov++;
        if (busy_o && SREQ_neg) gap_cnt++;
      end
      sreq_prev = SREQ_neg;
      if (SREQ_neg) begin
        TREQ_neg = 1'b1;
        gcnt = 0;
      end else if (TREQ_neg && gcnt == gnt_dly) begin
        TREQ_neg = 1'b0;
        t_gnt = cyc;
      end else if (TREQ_neg) begin
        gcnt++;
      end
    end
  end

  task automatic send(input int n, input int stall_at);
    int k;
    for (int i = 0; i < n; i++) begin
      valid_i = 1'b1;
      dat_i   = wq[i];
      last_i  = lq[i];
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!ready_o && k < 4000);
      if (!ready_o) expire($sformatf("handshake_%0d", i));
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      last_i  = 1'b0;
      if (i == stall_at) begin
        repeat (3) @(negedge clk);
        repeat (3) begin
          @(negedge clk);
          chk("stall_sclk", sclk_en_o, 1'b0);
          chk("stall_td", td_o, wq[i][31:24]);
        end
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (busy_o && k < 4000);
    if (busy_o) expire(tag);
  endtask

  task automatic add_frame(input int lo, input int hi);
    logic [7:0] c;
    logic [7:0] b;
    c = 8'hA5;
    exp_q.push_back(8'hA5);
    for (int i = lo; i <= hi; i++) begin
      for (int j = 0; j < 4; j++) begin
        b = wq[i][8*j +: 8];
        exp_q.push_back(b);
        c = c ^ b;
      end
    end
    exp_q.push_back(c);
  endtask

  task automatic check_rx(input string tag);
    chk({tag, "_len"}, rx.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
      chk($sformatf("%s_b%0d", tag, i), rx[i], exp_q[i]);
    end
  endtask

  task automatic clear_logs();
    rx.delete();
    rxc.delete();
    to_q.delete();
    exp_q.delete();
    n_ov = 0;
    gap_cnt = 0;
  endtask

  initial begin
    int k;
    rst_neg_i = 1'b0;
    dat_i     = '0;
    valid_i   = 1'b0;
    last_i    = 1'b0;
    #1;
    chk("reset_state",
        {SREQ_neg, td_o, sclk_en_o, ready_o, busy_o,
         overflow_o, timeout_o, frame_count_o},
        {1'b1, 29'h0});
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_neg_i = 1'b1;
    @(posedge clk);
    #1;

    // Single word, grant 5 cycles after request
    clear_logs();
    gnt_dly = 5;
    wq[0] = 32'h11223344; lq[0] = 1'b1;
    send(1, -1);
    wait_idle("t1_idle");
    exp_q = '{8'hA5, 8'h44, 8'h33, 8'h22, 8'h11, 8'hE1};
    check_rx("t1");
    chk("t1_grant_delay", t_gnt - req_start, 5);
    if (rxc.size() > 0) chk("t1_latency", rxc[0] - t_gnt, 3);
    chk("t1_frames", frame_count_o, 16'd1);
    chk("t1_gap", gap_cnt, 4);

    // Three back-to-back words
    clear_logs();
    gnt_dly = 1;
    wq[0] = 32'h03020100; lq[0] = 1'b0;
    wq[1] = 32'h07060504; lq[1] = 1'b0;
    wq[2] = 32'h0B0A0908; lq[2] = 1'b1;
    send(3, -1);
    wait_idle("t2_idle");
    add_frame(0, 2);
    check_rx("t2");
    if (rxc.size() == 14) chk("t2_no_bubble", rxc[13] - rxc[0], 13);
    chk("t2_frames", frame_count_o, 16'd2);

    // Valid dropped between two words: three stall cycles
    clear_logs();
    wq[0] = 32'hDEADBEEF; lq[0] = 1'b0;
    wq[1] = 32'h01234567; lq[1] = 1'b1;
    send(2, 0);
    wait_idle("t3_idle");
    add_frame(0, 1);
    check_rx("t3");
    if (rx.size() == 10) begin
      chk("t3_cks", rx[9], 8'h87);
      chk("t3_span", rxc[9] - rxc[0], 12);
    end

    // Grant withheld for 2500 cycles
    clear_logs();
    gnt_dly = 2500;
    wq[0] = 32'hCAFEF00D; lq[0] = 1'b1;
    send(1, -1);
    wait_idle("t4_idle");
    chk("t4_to_count", to_q.size(), 2);
    if (to_q.size() >= 2) begin
      chk("t4_to_first", to_q[0], 1024);
      chk("t4_to_second", to_q[1], 2048);
    end
    if (rxc.size() > 0) chk("t4_first_byte", rxc[0] - req_start, 2503);
    add_frame(0, 0);
    check_rx("t4");
    if (rx.size() == 6) chk("t4_cks", rx[5], 8'h6C);
    chk("t4_frames", frame_count_o, 16'd4);

    // Six-word event split by the 4-word limit
    clear_logs();
    gnt_dly = 2;
    wq[0] = 32'h89ABCDEF; lq[0] = 1'b0;
    wq[1] = 32'h13579BDF; lq[1] = 1'b0;
    wq[2] = 32'h2468ACE0; lq[2] = 1'b0;
    wq[3] = 32'hF0E1D2C3; lq[3] = 1'b0;
    wq[4] = 32'h55AA33CC; lq[4] = 1'b0;
    wq[5] = 32'h0F1E2D3C; lq[5] = 1'b1;
    send(6, -1);
    wait_idle("t5_idle");
    add_frame(0, 3);
    add_frame(4, 5);
    check_rx("t5");
    chk("t5_overflow", n_ov, 1);
    chk("t5_frames", frame_count_o, 16'd6);

    // Reset during data byte 2, then a clean frame
    clear_logs();
    gnt_dly = 1;
    wq[0] = 32'h5A6B7C8D; lq[0] = 1'b1;
    send(1, -1);
    k = 0;
    while (rx.size() < 3 && k < 100) begin
      @(posedge clk);
      k++;
    end
    if (rx.size() < 3) expire("t6_byte2");
    #2;
    chk("t6_pre_td", td_o, 8'h6B);
    rst_neg_i = 1'b0;
    #1;
    chk("t6_async_reset",
        {SREQ_neg, td_o, sclk_en_o, ready_o, busy_o,
         overflow_o, timeout_o, frame_count_o},
        {1'b1, 29'h0});
    repeat (2) @(negedge clk);
    rst_neg_i = 1'b1;
    @(posedge clk);
    #1;
    clear_logs();
    wq[0] = 32'h01020304; lq[0] = 1'b1;
    send(1, -1);
    wait_idle("t6_idle");
    add_frame(0, 0);
    check_rx("t6");
    chk("t6_frames", frame_count_o, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
